// File: rtl/biu_constants_pkg.sv
// -----------------------------------------------------------------------------
// biu_constants_pkg
//   Shared bus-interface-unit constants. Only the transfer-size encoding is
//   needed by the PMA arbiter.
// -----------------------------------------------------------------------------
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE       = 3'b000,
    HWORD      = 3'b001,
    WORD       = 3'b010,
    DWORD      = 3'b011,
    QWORD      = 3'b100,
    UNDEF_SIZE = 3'b111
  } biu_size_t;

endpackage : biu_constants_pkg

// File: rtl/riscv_pma_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pma_pkg
//   Types shared by the PMA checker and its IF/DM arbiter:
//     pma_arb_state_t : arbiter FSM states
//     pma_arb_port_t  : requesting port identifier
//     pma_chk_req_t   : captured checker request (request register layout)
//   PMA_PLEN is the widest physical address the request register holds; the
//   arbiter's PLEN parameter must not exceed it.
// -----------------------------------------------------------------------------
package riscv_pma_pkg;
  import biu_constants_pkg::*;

  localparam int PMA_PLEN = 34;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } pma_arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } pma_arb_port_t;

  typedef struct packed {
    logic                instruction;
    logic [PMA_PLEN-1:0] adr;
    biu_size_t           size;
    logic                we;
    logic                lock;
    logic                misaligned;
  } pma_chk_req_t;

  function automatic pma_arb_port_t other_port(input pma_arb_port_t p);
    return (p == PORT_IF) ? PORT_DM : PORT_IF;
  endfunction

endpackage : riscv_pma_pkg

// File: rtl/riscv_pma_arb.sv
// -----------------------------------------------------------------------------
// riscv_pma_arb
//   Shares one PMA checker between the instruction-fetch (IF) and data-memory
//   (DM) ports. The winner is captured into a request register that drives the
//   checker for one CHECK cycle; the verdict is registered and returned with a
//   one-cycle ack in RESP. Request seen in cycle N -> ack in cycle N+2.
//
//   Ports
//     clk_i, rst_i             clock, asynchronous active-high reset
//     if_*_i                   IF request (held until if_ack_o)
//     dm_*_i                   DM request (held until dm_ack_o)
//     chk_*_o                  request to the shared PMA checker
//     chk_*_i                  checker verdict (sampled in CHECK)
//     if_ack_o, dm_ack_o       one-cycle result-valid pulses
//     rsp_*_o                  registered verdict, held between acks
//
//   Parameters
//     PLEN      physical address width (<= PMA_PLEN)
//     MAX_WAIT  DM grants with IF pending before IF is forced (1..15)
//
//   Build option
//     RISCV_PMA_ARB_RR_EN  defined: round-robin between the ports.
//                          undefined: DM priority with MAX_WAIT starvation guard.
// -----------------------------------------------------------------------------
module riscv_pma_arb
  import biu_constants_pkg::*, riscv_pma_pkg::*;
#(
  parameter int PLEN     = PMA_PLEN,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            if_req_i,
  input  logic [PLEN-1:0] if_adr_i,
  input  biu_size_t       if_size_i,
  input  logic            if_misaligned_i,

  input  logic            dm_req_i,
  input  logic [PLEN-1:0] dm_adr_i,
  input  biu_size_t       dm_size_i,
  input  logic            dm_we_i,
  input  logic            dm_lock_i,
  input  logic            dm_misaligned_i,

  output logic            chk_req_o,
  output logic            chk_instruction_o,
  output logic [PLEN-1:0] chk_adr_o,
  output biu_size_t       chk_size_o,
  output logic            chk_we_o,
  output logic            chk_lock_o,
  output logic            chk_misaligned_o,
  input  logic            chk_exception_i,
  input  logic            chk_misaligned_i,
  input  logic            chk_cacheable_i,

  output logic            if_ack_o,
  output logic            dm_ack_o,
  output logic            rsp_exception_o,
  output logic            rsp_misaligned_o,
  output logic            rsp_cacheable_o
);

  pma_arb_state_t state_q, state_d;
  pma_arb_port_t  winner_q, winner_d;
  pma_arb_port_t  sel;
  pma_chk_req_t   req_q, req_d;
  logic           if_elig, dm_elig, grant;

`ifdef RISCV_PMA_ARB_RR_EN
  pma_arb_port_t  rr_ptr_q, rr_ptr_d;
`else
  logic [3:0]     wait_cnt_q, wait_cnt_d;
`endif

  // Arbitration. The port being acked in RESP has just been served and may
  // not win again in the same cycle, which gives the other port its turn.
  always_comb begin : arbitrate
    if_elig = if_req_i && !(state_q == RESP && winner_q == PORT_IF);
    dm_elig = dm_req_i && !(state_q == RESP && winner_q == PORT_DM);
    grant   = (state_q != CHECK) && (if_elig || dm_elig);
    sel     = dm_elig ? PORT_DM : PORT_IF;
    if (if_elig && dm_elig) begin
`ifdef RISCV_PMA_ARB_RR_EN
      sel = rr_ptr_q;
`else
      sel = (wait_cnt_q == 4'(MAX_WAIT)) ? PORT_IF : PORT_DM;
`endif
    end
  end

  always_comb begin : fsm_next
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if structure can leave one unassigned and infer a latch.
    state_d   = state_q;
    winner_d  = winner_q;
    req_d     = req_q;
    chk_req_o = 1'b0;
    if_ack_o  = 1'b0;
    dm_ack_o  = 1'b0;
`ifdef RISCV_PMA_ARB_RR_EN
    rr_ptr_d  = rr_ptr_q;
`else
    wait_cnt_d = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE:    if (grant) state_d = CHECK;
      CHECK: begin
        chk_req_o = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if_ack_o = (winner_q == PORT_IF);
        dm_ack_o = (winner_q == PORT_DM);
        state_d  = grant ? CHECK : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      winner_d = sel;
      if (sel == PORT_IF) begin
        // Instruction fetches never write or lock.
        req_d = '{instruction: 1'b1, adr: PMA_PLEN'(if_adr_i), size: if_size_i,
                  we: 1'b0, lock: 1'b0, misaligned: if_misaligned_i};
      end else begin
        req_d = '{instruction: 1'b0, adr: PMA_PLEN'(dm_adr_i), size: dm_size_i,
                  we: dm_we_i, lock: dm_lock_i, misaligned: dm_misaligned_i};
      end
`ifdef RISCV_PMA_ARB_RR_EN
      rr_ptr_d = other_port(sel);
`else
      // Count DM wins that leave IF waiting; saturate at MAX_WAIT.
      if (sel == PORT_IF) begin
        wait_cnt_d = '0;
      end else if (if_req_i && wait_cnt_q != 4'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : regs
    if (rst_i) begin
      state_q          <= IDLE;
      winner_q         <= PORT_IF;
      req_q            <= '0;
      rsp_exception_o  <= 1'b0;
      rsp_misaligned_o <= 1'b0;
      rsp_cacheable_o  <= 1'b0;
`ifdef RISCV_PMA_ARB_RR_EN
      rr_ptr_q         <= PORT_DM;
`else
      wait_cnt_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // regardless of statement order in this block.
      state_q  <= state_d;
      winner_q <= winner_d;
      req_q    <= req_d;
      // Verdict only moves on the CHECK->RESP edge and is held otherwise.
      if (state_q == CHECK) begin
        rsp_exception_o  <= chk_exception_i;
        rsp_misaligned_o <= chk_misaligned_i;
        rsp_cacheable_o  <= chk_cacheable_i;
      end
`ifdef RISCV_PMA_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`else
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign chk_instruction_o = req_q.instruction;
  assign chk_adr_o         = PLEN'(req_q.adr);
  assign chk_size_o        = req_q.size;
  assign chk_we_o          = req_q.we;
  assign chk_lock_o        = req_q.lock;
  assign chk_misaligned_o  = req_q.misaligned;

endmodule : riscv_pma_arb
